// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle MIPS controller.
//   state_t  - FSM state with fixed 4-bit encodings (visible on state_o)
//   OP_*     - instr[31:26] opcodes understood by the decoder
//   ALUOP_*, SRCB_*, PCSRC_* - datapath mux/ALU select encodings
//   ctrl_t   - bundle of every control output driven per cycle
//   op_legal - whether an opcode is decodable under the enabled options
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       pcwrite;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op,
                                    input logic       en_addi,
                                    input logic       en_jump);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ: return 1'b1;
      OP_ADDI:                        return en_addi;
      OP_J:                           return en_jump;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// mc_ctrl_out_decode: combinational control-output decode for the
// multicycle controller.
//   state - current FSM state
//   go    - memory access completes this cycle (already WAIT_MEM-qualified)
//   ctrl  - all datapath controls plus mem_req and instr_done
// Only FETCH and MEMWRITE look at go, so a stalled access holds every
// output steady until memory answers.
module mc_ctrl_out_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   go,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl         = '0;
    ctrl.alusrcb = SRCB_REGB;
    ctrl.aluop   = ALUOP_ADD;
    ctrl.pcsrc   = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        // PC+4 through the ALU; IR and PC only capture once data is back
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = go;
        ctrl.pcwrite = go;
      end
      S_DECODE: ctrl.alusrcb = SRCB_IMMSH;  // precompute branch target
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl.iord    = 1'b1;
        ctrl.mem_req = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.mem_req    = 1'b1;
        ctrl.instr_done = go;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.branch     = 1'b1;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ;  // IDLE, TRAP: everything low
    endcase
  end

endmodule

// File: rtl/mc_main_controller.sv
// mc_main_controller: multicycle MIPS control unit.
//   clk, rst           - clock, asynchronous active-high reset
//   opcode             - instr[31:26] from the IR, used in DECODE/MEMADR
//   mem_ready          - memory finishes the current access
//   mem_req ... PCSrc  - datapath controls, decoded from current state
//   instr_done         - pulse on the last cycle of each instruction
//   illegal_op         - sticky flag, set after decoding a bad opcode
//   retire_count       - wrapping count of completed instructions
//   state_o            - current state encoding
module mc_main_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit          SUPPORT_ADDI    = 1'b1,
  parameter bit          SUPPORT_JUMP    = 1'b1,
  parameter bit          WAIT_MEM        = 1'b1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned RETIRE_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                IorD,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic                Branch,
  output logic                PCWrite,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSrc,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retire_count,
  output logic [3:0]          state_o
);

  state_t state, state_n;
  ctrl_t  ctrl;
  logic   go;
  logic   dec_illegal;

  // without wait states every access is assumed to finish in one cycle
  assign go          = mem_ready | ~WAIT_MEM;
  assign dec_illegal = (state == S_DECODE) &&
                       !op_legal(opcode, SUPPORT_ADDI, SUPPORT_JUMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = S_FETCH;
      S_FETCH: if (go) state_n = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) state_n = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
        else begin
          case (opcode)
            OP_LW, OP_SW: state_n = S_MEMADR;
            OP_RTYPE:     state_n = S_EXECUTE;
            OP_BEQ:       state_n = S_BRANCH;
            OP_ADDI:      state_n = S_ADDIEXEC;
            OP_J:         state_n = S_JUMP;
            default:      state_n = S_TRAP;  // excluded by dec_illegal
          endcase
        end
      end
      // IR still holds the opcode, so it picks the load or store leg
      S_MEMADR:   state_n = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (go) state_n = S_MEMWB;
      S_MEMWRITE: if (go) state_n = S_FETCH;
      S_EXECUTE:  state_n = S_ALUWB;
      S_ADDIEXEC: state_n = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_n = S_FETCH;
      S_TRAP:     state_n = S_TRAP;  // only reset leaves
      default:    state_n = S_IDLE;
    endcase
  end

  mc_ctrl_out_decode u_out (
    .state (state),
    .go    (go),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                retire_count <= '0;
    else if (ctrl.instr_done) retire_count <= retire_count + RETIRE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              illegal_op <= 1'b0;
    else if (dec_illegal) illegal_op <= 1'b1;
  end

  assign mem_req    = ctrl.mem_req;
  assign IorD       = ctrl.iord;
  assign IRWrite    = ctrl.irwrite;
  assign MemWrite   = ctrl.memwrite;
  assign MemtoReg   = ctrl.memtoreg;
  assign RegDst     = ctrl.regdst;
  assign RegWrite   = ctrl.regwrite;
  assign ALUSrcA    = ctrl.alusrca;
  assign Branch     = ctrl.branch;
  assign PCWrite    = ctrl.pcwrite;
  assign ALUSrcB    = ctrl.alusrcb;
  assign ALUOp      = ctrl.aluop;
  assign PCSrc      = ctrl.pcsrc;
  assign instr_done = ctrl.instr_done;
  assign state_o    = state;

endmodule

// File: tb/tb_mc_main_controller.sv
// Bench for mc_main_controller. Three instances with different option
// sets are exercised one at a time (the others held in reset). Each
// instruction is expanded into its expected cycle-by-cycle walk, with
// random memory stalls, and every cycle the state, control vector,
// retire count and illegal flag are compared against that walk.
module tb_mc_main_controller;

  localparam int N = 3;
  localparam bit WM_P   [N] = '{1'b1, 1'b0, 1'b1};
  localparam bit HALT_P [N] = '{1'b1, 1'b0, 1'b1};
  localparam bit ADDI_P [N] = '{1'b1, 1'b0, 1'b1};
  localparam bit JMP_P  [N] = '{1'b1, 1'b1, 1'b0};
  localparam int RW_P   [N] = '{32, 4, 8};

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                 ST_MEMREAD = 4, ST_MEMWB = 5, ST_MEMWRITE = 6,
                 ST_EXECUTE = 7, ST_ALUWB = 8, ST_BRANCH = 9,
                 ST_ADDIEXEC = 10, ST_ADDIWB = 11, ST_JUMP = 12, ST_TRAP = 13;

  localparam logic [5:0] R_OP = 6'b000000, J_OP = 6'b000010,
                         BEQ_OP = 6'b000100, ADDI_OP = 6'b001000,
                         LW_OP = 6'b100011, SW_OP = 6'b101011;

  logic        clk = 1'b0;
  logic        rst_a [N];
  logic [5:0]  opc   [N];
  logic        mr    [N];
  logic [3:0]  st_o  [N];
  logic [16:0] ctl   [N];
  logic [31:0] ret   [N];
  logic        ill   [N];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int unsigned exp_ret [N];
  bit          exp_ill [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic mem_req, iord, irw, mw, m2r, rdst, rw, sa, br, pcw, done, illo;
    logic [1:0] sb, aop, pcs;
    logic [3:0] so;
    logic [RW_P[g]-1:0] rc;

    mc_main_controller #(
      .SUPPORT_ADDI(ADDI_P[g]), .SUPPORT_JUMP(JMP_P[g]), .WAIT_MEM(WM_P[g]),
      .HALT_ON_ILLEGAL(HALT_P[g]), .RETIRE_W(RW_P[g])
    ) u_dut (
      .clk(clk), .rst(rst_a[g]), .opcode(opc[g]), .mem_ready(mr[g]),
      .mem_req(mem_req), .IorD(iord), .IRWrite(irw), .MemWrite(mw),
      .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rw), .ALUSrcA(sa),
      .Branch(br), .PCWrite(pcw), .ALUSrcB(sb), .ALUOp(aop), .PCSrc(pcs),
      .instr_done(done), .illegal_op(illo), .retire_count(rc), .state_o(so)
    );

    assign ctl[g]  = {mem_req, iord, irw, mw, m2r, rdst, rw, sa, br, pcw,
                      sb, aop, pcs, done};
    assign ret[g]  = 32'(rc);
    assign ill[g]  = illo;
    assign st_o[g] = so;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // expected control vector for a state, in the same bit order as ctl[]
  function automatic logic [16:0] exp_ctrl(input int st, input bit g);
    logic mreq, iord, irw, mw, m2r, rdst, rw, sa, br, pcw, done;
    logic [1:0] sb, aop, pcs;
    {mreq, iord, irw, mw, m2r, rdst, rw, sa, br, pcw, done} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      ST_FETCH:    begin mreq = 1; sb = 2'b01; irw = g; pcw = g; end
      ST_DECODE:   sb = 2'b11;
      ST_MEMADR:   begin sa = 1; sb = 2'b10; end
      ST_MEMREAD:  begin iord = 1; mreq = 1; end
      ST_MEMWB:    begin rw = 1; m2r = 1; done = 1; end
      ST_MEMWRITE: begin iord = 1; mw = 1; mreq = 1; done = g; end
      ST_EXECUTE:  begin sa = 1; aop = 2'b10; end
      ST_ALUWB:    begin rdst = 1; rw = 1; done = 1; end
      ST_BRANCH:   begin sa = 1; aop = 2'b01; br = 1; pcs = 2'b01; done = 1; end
      ST_ADDIEXEC: begin sa = 1; sb = 2'b10; end
      ST_ADDIWB:   begin rw = 1; done = 1; end
      ST_JUMP:     begin pcw = 1; pcs = 2'b10; done = 1; end
      default: ;
    endcase
    return {mreq, iord, irw, mw, m2r, rdst, rw, sa, br, pcw, sb, aop, pcs, done};
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom % 6)
      0: return R_OP;
      1: return J_OP;
      2: return BEQ_OP;
      3: return ADDI_OP;
      4: return LW_OP;
      default: return SW_OP;
    endcase
  endfunction

  function automatic int unsigned rmask(input int d);
    return (RW_P[d] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << RW_P[d]) - 1);
  endfunction

  // one clock cycle: drive inputs on the falling edge, check 1 ns later
  task automatic step(input int d, input int st, input bit g,
                      input logic [5:0] op, input logic m, input logic r);
    logic [16:0] e;
    @(negedge clk);
    rst_a[d] = r; opc[d] = op; mr[d] = m;
    #1;
    cyc++;
    e = exp_ctrl(st, g);
    check($sformatf("d%0d c%0d state", d, cyc), 32'(st_o[d]), 32'(st));
    check($sformatf("d%0d c%0d ctrl", d, cyc), 32'(ctl[d]), 32'(e));
    check($sformatf("d%0d c%0d retire", d, cyc), ret[d], exp_ret[d]);
    check($sformatf("d%0d c%0d illegal", d, cyc), 32'(ill[d]), 32'(exp_ill[d]));
    if (e[0]) exp_ret[d] = (exp_ret[d] + 1) & rmask(d);
  endtask

  task automatic do_reset(input int d);
    exp_ret[d] = 0; exp_ill[d] = 1'b0;
    step(d, ST_IDLE, 0, r6(), rbit(), 1'b1);
    step(d, ST_IDLE, 0, r6(), rbit(), 1'b1);
    step(d, ST_IDLE, 0, r6(), rbit(), 1'b0);
  endtask

  // sf / sm: stall cycles in FETCH and in the data access
  task automatic run_instr(input int d, input logic [5:0] op,
                           input int sf_in, input int sm_in);
    bit wm;
    bit legal;
    int sf, sm;
    wm = WM_P[d];
    sf = wm ? sf_in : 0;
    sm = wm ? sm_in : 0;
    repeat (sf) step(d, ST_FETCH, 0, r6(), 1'b0, 1'b0);
    step(d, ST_FETCH, 1, r6(), wm ? 1'b1 : rbit(), 1'b0);
    step(d, ST_DECODE, 1, op, rbit(), 1'b0);
    legal = (op == R_OP) || (op == BEQ_OP) || (op == LW_OP) || (op == SW_OP) ||
            (op == ADDI_OP && ADDI_P[d]) || (op == J_OP && JMP_P[d]);
    if (!legal) begin
      exp_ill[d] = 1'b1;
      if (HALT_P[d]) repeat (20) step(d, ST_TRAP, 0, r6(), rbit(), 1'b0);
      return;
    end
    case (op)
      LW_OP: begin
        step(d, ST_MEMADR, 1, op, rbit(), 1'b0);
        repeat (sm) step(d, ST_MEMREAD, 0, op, 1'b0, 1'b0);
        step(d, ST_MEMREAD, 1, op, wm ? 1'b1 : rbit(), 1'b0);
        step(d, ST_MEMWB, 1, op, rbit(), 1'b0);
      end
      SW_OP: begin
        step(d, ST_MEMADR, 1, op, rbit(), 1'b0);
        repeat (sm) step(d, ST_MEMWRITE, 0, op, 1'b0, 1'b0);
        step(d, ST_MEMWRITE, 1, op, wm ? 1'b1 : rbit(), 1'b0);
      end
      R_OP: begin
        step(d, ST_EXECUTE, 1, op, rbit(), 1'b0);
        step(d, ST_ALUWB, 1, op, rbit(), 1'b0);
      end
      BEQ_OP: step(d, ST_BRANCH, 1, op, rbit(), 1'b0);
      ADDI_OP: begin
        step(d, ST_ADDIEXEC, 1, op, rbit(), 1'b0);
        step(d, ST_ADDIWB, 1, op, rbit(), 1'b0);
      end
      default: step(d, ST_JUMP, 1, op, rbit(), 1'b0);
    endcase
  endtask

  // store stalled in MEMWRITE, then reset hits mid-cycle
  task automatic mid_reset(input int d);
    step(d, ST_FETCH, 1, r6(), 1'b1, 1'b0);
    step(d, ST_DECODE, 1, SW_OP, rbit(), 1'b0);
    step(d, ST_MEMADR, 1, SW_OP, rbit(), 1'b0);
    step(d, ST_MEMWRITE, 0, SW_OP, 1'b0, 1'b0);
    #2 rst_a[d] = 1'b1;
    #1;
    exp_ret[d] = 0; exp_ill[d] = 1'b0;
    check("midrst state", 32'(st_o[d]), 32'(ST_IDLE));
    check("midrst ctrl", 32'(ctl[d]), 32'd0);
    check("midrst retire", ret[d], 32'd0);
    step(d, ST_IDLE, 0, r6(), rbit(), 1'b1);
    step(d, ST_IDLE, 0, r6(), rbit(), 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst_a[i] = 1'b1; opc[i] = '0; mr[i] = 1'b0;
      exp_ret[i] = 0; exp_ill[i] = 1'b0;
    end

    // default options: wait states, trap on illegal
    do_reset(0);
    run_instr(0, R_OP, 0, 0);
    run_instr(0, LW_OP, 2, 2);
    run_instr(0, SW_OP, 0, 1);
    run_instr(0, BEQ_OP, 1, 0);
    run_instr(0, J_OP, 0, 0);
    run_instr(0, ADDI_OP, 3, 0);
    for (int i = 0; i < 30; i++)
      run_instr(0, pick_op(), $urandom % 4, $urandom % 4);
    mid_reset(0);
    run_instr(0, LW_OP, 1, 0);
    run_instr(0, R_OP, 0, 0);
    run_instr(0, 6'b111111, 0, 0);

    // no wait states, illegal skipped, no addi, 4-bit counter
    do_reset(1);
    run_instr(1, SW_OP, 0, 0);
    run_instr(1, BEQ_OP, 0, 0);
    run_instr(1, J_OP, 0, 0);
    run_instr(1, ADDI_OP, 0, 0);
    run_instr(1, 6'b111111, 0, 0);
    for (int i = 0; i < 40; i++)
      run_instr(1, rbit() ? pick_op() : r6(), 0, 0);

    // jump disabled, traps on j
    do_reset(2);
    run_instr(2, R_OP, 0, 0);
    run_instr(2, ADDI_OP, 1, 0);
    run_instr(2, LW_OP, 1, 1);
    run_instr(2, J_OP, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_main_controller.md
# mc_main_controller

Multicycle control unit for the MIPS datapath, the sequential successor to the single-cycle main decoder. A state machine walks each instruction through fetch, decode, execute, memory and writeback cycles, driving the shared ALU/memory datapath's mux selects and write enables. It adds parametrised instruction support, memory wait-state handling, illegal-opcode trapping and a retired-instruction counter.

## Interface
- SUPPORT_ADDI, default 1: if 1, decode addi (001000); if 0, addi is illegal.
- SUPPORT_JUMP, default 1: if 1, decode j (000010); if 0, j is illegal.
- WAIT_MEM, default 1: if 1, memory states hold until mem_ready; if 0, mem_ready is ignored (treated as 1).
- HALT_ON_ILLEGAL, default 1: if 1, an illegal opcode parks the machine in TRAP; if 0, it is skipped as a NOP.
- RETIRE_W, default 32: width of the retired-instruction counter.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register; sampled in DECODE.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access in progress (FETCH, MEMREAD, MEMWRITE).
- IorD, IRWrite, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Branch, PCWrite  out  1 each  datapath controls.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded.
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op  out  1  sticky; cleared only by reset.
- retire_count  out  RETIRE_W  completed-instruction count, wraps modulo 2^RETIRE_W.
- state_o  out  4  current state encoding, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, TRAP.
- Memory completion: go = mem_ready | ~WAIT_MEM.
- Sequencing per state:
  - IDLE: all outputs 0; go to FETCH.
  - FETCH: mem_req=1, ALUSrcB=01; IRWrite=PCWrite=go. Stay in FETCH until go, then DECODE.
  - DECODE: ALUSrcB=11. Dispatch on opcode:
    - lw (100011) or sw (101011) → MEMADR
    - R-type (000000) → EXECUTE
    - beq (000100) → BRANCH
    - addi → ADDIEXEC
    - j → JUMP
    - anything else, or a disabled opcode → illegal.
  - MEMADR: ALUSrcA=1, ALUSrcB=10. Go to MEMREAD for lw, MEMWRITE for sw; the opcode is held in the instruction register.
  - MEMREAD: IorD=1, mem_req=1. Go to MEMWB on go.
  - MEMWB: RegWrite=1, MemtoReg=1, instr_done=1.
  - MEMWRITE: IorD=1, MemWrite=1, mem_req=1. instr_done=go; go to FETCH on go.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1, instr_done=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, Branch=1, PCSrc=01, instr_done=1.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1, instr_done=1.
  - JUMP: PCWrite=1, PCSrc=10, instr_done=1.
- Any output not listed for a state is 0 in that state.
- MEMWB, ALUWB, BRANCH, ADDIWB and JUMP go to FETCH.
- Illegal opcode: illegal_op←1.
  - HALT_ON_ILLEGAL=1: go to TRAP. All outputs are 0 and the machine stays in TRAP until reset.
  - HALT_ON_ILLEGAL=0: go to FETCH; no instr_done, no retire increment.
- retire_count increments on every cycle where instr_done=1.

## Timing
- Reset (async): state=IDLE, retire_count=0, illegal_op=0, all control outputs 0.
  - The first FETCH is one cycle after reset deasserts.
  - Reset asserted mid-instruction aborts it immediately; no partial writeback.
- Zero-wait latency, in cycles:
  - beq 3, j 3
  - R-type 4, sw 4, addi 4
  - lw 5
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE (WAIT_MEM=1) adds one cycle. No outputs change while stalled.
- Control outputs are decoded from the current state (plus go in FETCH and MEMWRITE); no registered output delay.
- retire_count and illegal_op update on the clock edge after the qualifying cycle.
- Counter wraps from all-ones to 0 with no flag.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum with fixed 4-bit encodings (IDLE=0 … TRAP=13), which define state_o;
  - opcode constants;
  - ALUOp, ALUSrcB and PCSrc encoding constants.
- One sub-module, mc_ctrl_out_decode: purely combinational, (state, go) → all control outputs.
- The top holds the state register, next-state logic, retire counter and illegal flag.

## Test plan
- Reset, then R-type with mem_ready=1 → state_o sequence IDLE, FETCH, DECODE, EXECUTE, ALUWB, FETCH; one instr_done; retire_count=1.
- lw with mem_ready=0 for 2 cycles in both FETCH and MEMREAD → 9 cycles FETCH-to-FETCH; IRWrite/PCWrite high only in the ready FETCH cycle; MemtoReg=1 in MEMWB.
- Sequence sw, beq, j, addi at WAIT_MEM=0 → MemWrite high exactly 1 cycle; PCSrc 01 then 10; retire_count=4 after 14 cycles.
- Opcode 111111 with HALT_ON_ILLEGAL=1 → TRAP, illegal_op=1, all outputs 0 for 20 cycles. Repeat with HALT_ON_ILLEGAL=0 → back to FETCH, retire_count unchanged.
- SUPPORT_ADDI=0 with opcode 001000 → illegal path. RETIRE_W=4 with 17 instructions → retire_count=1.
- Reset asserted during MEMWRITE → outputs 0 in the same cycle, retire_count=0; IDLE then FETCH after release.
